// File: rtl/vedic_mac_accum.sv
// vedic_mac_accum: accumulates the unsigned product stream of the 4x4 Vedic
// multiplier into one saturating sum per frame. A frame closes on in_last or
// after MAX_TERMS beats. The result is then held for a valid/ready consumer.
module vedic_mac_accum #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [0:0]       S_ACC  = 1'b0;
    localparam logic [0:0]       S_HOLD = 1'b1;
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_TERMS);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W:0]   add_res;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating add: once the carry appears (or saturation already happened
    // this frame) the sum pins at all-ones. Returns {ovf, sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p,
                                               input logic sticky);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(p);
        if (s[ACC_W] || sticky) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    // Next-state: clear aborts everything, ACC takes beats, HOLD waits for out_ready.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        add_res     = sat_add(acc_q, in_prod, ovf_q);
        cnt_inc     = cnt_q + CNT_W'(1);
        if (clear) begin
            state_d = S_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == S_ACC) begin
            if (in_valid) begin
                if (in_last || (cnt_inc == MAX_C)) begin
                    // Final beat: publish the result and restart the accumulator.
                    state_d     = S_HOLD;
                    out_sum_d   = add_res[ACC_W-1:0];
                    out_count_d = cnt_inc;
                    out_ovf_d   = add_res[ACC_W];
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    acc_d = add_res[ACC_W-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = add_res[ACC_W];
                end
            end
        end else if (out_ready) begin
            state_d = S_ACC;
        end
    end

    // State and result registers; reset drops any frame or held result at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_vedic_mac_accum.sv
// tb_vedic_mac_accum: drives a 16-bit and a 10-bit accumulator with the same
// stimulus and checks both against a frame-level reference model.
module tb_vedic_mac_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_prod = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic        rdy16, vld16, ovf16;
    logic [15:0] sum16;
    logic [4:0]  cnt16;
    logic        rdy10, vld10, ovf10;
    logic [9:0]  sum10;
    logic [4:0]  cnt10;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integer frame sum, term count, held results.
    bit      m_hold = 0;
    longint  m_sum = 0;
    int      m_cnt = 0;
    longint  h_sum = 0;
    int      h_cnt = 0;

    always #5 clk = ~clk;

    vedic_mac_accum #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16), .CNT_W(5)) u16 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy16),
        .in_prod(in_prod), .in_last(in_last), .out_valid(vld16), .out_ready(out_ready),
        .out_sum(sum16), .out_count(cnt16), .out_ovf(ovf16));

    vedic_mac_accum #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16), .CNT_W(5)) u10 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy10),
        .in_prod(in_prod), .in_last(in_last), .out_valid(vld10), .out_ready(out_ready),
        .out_sum(sum10), .out_count(cnt10), .out_ovf(ovf10));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint satv(input longint s, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic check_outputs();
        chk("in_ready16", rdy16, !m_hold);
        chk("out_valid16", vld16, m_hold);
        chk("in_ready10", rdy10, !m_hold);
        chk("out_valid10", vld10, m_hold);
        if (m_hold) begin
            chk("sum16", sum16, satv(h_sum, 16));
            chk("ovf16", ovf16, h_sum > 65535);
            chk("cnt16", cnt16, h_cnt);
            chk("sum10", sum10, satv(h_sum, 10));
            chk("ovf10", ovf10, h_sum > 1023);
            chk("cnt10", cnt10, h_cnt);
        end
    endtask

    // Apply current inputs across one rising edge, update the model, then check.
    task automatic tick();
        if (clear) begin
            m_hold = 0; m_sum = 0; m_cnt = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                m_sum += in_prod;
                m_cnt++;
                if (in_last || m_cnt == 16) begin
                    m_hold = 1; h_sum = m_sum; h_cnt = m_cnt;
                    m_sum = 0; m_cnt = 0;
                end
            end
        end else if (out_ready) begin
            m_hold = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic beat(input int p, input bit last);
        in_valid = 1'b1; in_prod = 8'(p); in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rdy", rdy16, 1); chk("rst_vld", vld16, 0);
        chk("rst_sum", sum16, 0); chk("rst_cnt", cnt16, 0); chk("rst_ovf", ovf16, 0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Basic frame
        beat(15, 0); beat(63, 0); beat(225, 1);
        chk("basic_sum", sum16, 303);
        tick(); tick();
        drain();

        // Forced termination at 16 terms, 17th beat must wait
        for (int i = 0; i < 16; i++) beat(225, 0);
        chk("force_cnt", cnt16, 16);
        in_valid = 1'b1; in_prod = 8'd225; tick(); tick();
        in_valid = 1'b0;
        drain();

        // Saturation on the 10-bit instance, then a clean frame
        for (int i = 0; i < 5; i++) beat(225, i == 4);
        chk("sat_ovf10", ovf10, 1);
        drain();
        beat(4, 1);
        chk("post_sat_sum10", sum10, 4);
        drain();

        // Backpressure: pending beat held off, then taken as term 1
        beat(15, 0); beat(63, 0); beat(225, 1);
        in_valid = 1'b1; in_prod = 8'd99; in_last = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_cnt", cnt16, 1);
        drain();

        // Clear drops the beat presented with it
        beat(10, 0); beat(20, 0);
        clear = 1'b1; in_valid = 1'b1; in_prod = 8'd30; tick();
        clear = 1'b0; in_valid = 1'b0;
        beat(7, 1);
        chk("clr_sum", sum16, 7);
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_hold_vld", vld16, 0);
        tick();

        // Async reset mid-frame, then a one-term frame
        beat(50, 0);
        #2; rst = 1'b1; #1;
        chk("arst_vld", vld16, 0); chk("arst_rdy", rdy16, 1);
        m_hold = 0; m_sum = 0; m_cnt = 0;
        @(negedge clk); rst = 1'b0;
        beat(9, 1);
        chk("arst_sum", sum16, 9); chk("arst_cnt", cnt16, 1);
        drain();

        // Zero product still counts; in_last on the 16th beat closes once
        for (int i = 0; i < 16; i++) beat(0, i == 15);
        chk("last16_cnt", cnt16, 16);
        drain();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prod   = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
